// File: rtl/npu_pkg.sv
// Shared NPU datapath constants and the tap-sequencer state type.
`timescale 1ns/1ps
package npu_pkg;

  localparam int NPU_DW        = 8;
  localparam int NPU_TAPS      = 9;
  localparam int NPU_TREE_PIPE = 3;
  localparam int NPU_ACC_W     = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } npu_state_e;

endpackage

// File: rtl/mac_vld_delay.sv
// PIPE-deep valid shift register with synchronous clear. sr[PIPE-1] is high
// exactly PIPE cycles after din was high, matching a fixed-latency datapath.
`timescale 1ns/1ps
module mac_vld_delay #(
  parameter int PIPE = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            din,
  output logic [PIPE-1:0] sr
);

  genvar gi;
  generate
    for (gi = 0; gi < PIPE; gi++) begin : g_stage
      logic stage_in;
      logic stage_reg;

      if (gi == 0) begin : g_first
        assign stage_in = din;
      end else begin : g_rest
        assign stage_in = sr[gi-1];
      end

      // advance the valid token one stage per clock; clear drops all tokens
      always_ff @(posedge clk) begin
        if (clr) stage_reg <= 1'b0;
        else     stage_reg <= stage_in;
      end

      assign sr[gi] = stage_reg;
    end
  endgenerate

endmodule

// File: rtl/mac_tap_sequencer.sv
// Sequences one convolution window through the pipelined multiplier /
// adder-tree: issues operand pairs, counts returning products, accumulates
// them and presents the sum on a valid/ready result port.
`timescale 1ns/1ps
module mac_tap_sequencer
  import npu_pkg::*;
#(
  parameter int DW    = NPU_DW,
  parameter int TAPS  = NPU_TAPS,
  parameter int PIPE  = NPU_TREE_PIPE,
  parameter int ACC_W = NPU_ACC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4:0]             cfg_taps,
  output logic                   cfg_err,
  output logic                   busy,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic signed [DW-1:0]   op_a,
  input  logic signed [DW-1:0]   op_b,
  output logic                   tree_vld,
  output logic signed [DW-1:0]   tree_a,
  output logic signed [DW-1:0]   tree_b,
  input  logic signed [2*DW-1:0] tree_p,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_W-1:0]       res_data
);

  npu_state_e       state_reg, state_next;
  logic [4:0]       n_reg, n_next;
  logic [4:0]       issue_cnt_reg, issue_cnt_next;
  logic [4:0]       ret_cnt_reg, ret_cnt_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic             cfg_err_reg, cfg_err_next;
  logic [PIPE-1:0]  vld_sr;
  logic             ret_hit;
  logic             cfg_ok;
  logic [ACC_W-1:0] p_ext;

  // tree_p is signed, so the width cast sign-extends into the accumulator
  assign p_ext   = ACC_W'(tree_p);
  assign cfg_ok  = (cfg_taps != 5'd0) && (int'(cfg_taps) <= TAPS);
  // products only count while a window is live; stragglers in IDLE/OUT are dropped
  assign ret_hit = vld_sr[PIPE-1] && ((state_reg == ISSUE) || (state_reg == DRAIN));

  assign busy      = (state_reg != IDLE);
  assign op_ready  = (state_reg == ISSUE);
  assign tree_vld  = op_valid & op_ready;
  assign tree_a    = op_a;
  assign tree_b    = op_b;
  assign res_valid = (state_reg == OUT);
  assign res_data  = acc_reg;
  assign cfg_err   = cfg_err_reg;

  mac_vld_delay #(
    .PIPE (PIPE)
  ) u_vld_delay (
    .clk (clk),
    .clr (reset),
    .din (tree_vld),
    .sr  (vld_sr)
  );

  // next-state, counter and accumulator logic
  always_comb begin
    state_next     = state_reg;
    n_next         = n_reg;
    issue_cnt_next = issue_cnt_reg;
    ret_cnt_next   = ret_cnt_reg;
    acc_next       = acc_reg;
    cfg_err_next   = 1'b0;

    if (ret_hit) begin
      acc_next     = acc_reg + p_ext;
      ret_cnt_next = ret_cnt_reg + 5'd1;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            n_next         = cfg_taps;
            acc_next       = '0;
            issue_cnt_next = '0;
            ret_cnt_next   = '0;
            state_next     = ISSUE;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (tree_vld) begin
          issue_cnt_next = issue_cnt_reg + 5'd1;
          if (issue_cnt_reg == n_reg - 5'd1) state_next = DRAIN;
        end
      end
      DRAIN: begin
        // the final return and the move to OUT share one edge
        if (ret_cnt_next == n_reg) state_next = OUT;
      end
      OUT: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      issue_cnt_reg <= '0;
      ret_cnt_reg   <= '0;
      acc_reg       <= '0;
      cfg_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      n_reg         <= n_next;
      issue_cnt_reg <= issue_cnt_next;
      ret_cnt_reg   <= ret_cnt_next;
      acc_reg       <= acc_next;
      cfg_err_reg   <= cfg_err_next;
    end
  end

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Directed bench for mac_tap_sequencer with a PIPE-stage model multiplier.
`timescale 1ns/1ps
module tb_mac_tap_sequencer;

  localparam int DW    = 8;
  localparam int TAPS  = 9;
  localparam int PIPE  = 3;
  localparam int ACC_W = 20;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [4:0]             cfg_taps;
  logic                   cfg_err;
  logic                   busy;
  logic                   op_valid;
  logic                   op_ready;
  logic signed [DW-1:0]   op_a, op_b;
  logic                   tree_vld;
  logic signed [DW-1:0]   tree_a, tree_b;
  logic signed [2*DW-1:0] tree_p;
  logic                   res_valid;
  logic                   res_ready;
  logic [ACC_W-1:0]       res_data;

  logic signed [2*DW-1:0] p_pipe [PIPE];
  logic signed [DW-1:0]   va [16];
  logic signed [DW-1:0]   vb [16];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [ACC_W-1:0] res;
  int lat;

  mac_tap_sequencer #(
    .DW(DW), .TAPS(TAPS), .PIPE(PIPE), .ACC_W(ACC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_taps  (cfg_taps),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .tree_vld  (tree_vld),
    .tree_a    (tree_a),
    .tree_b    (tree_b),
    .tree_p    (tree_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // model multiplier: product of the pair seen at cycle k appears at cycle k+PIPE
  always @(posedge clk) begin
    p_pipe[0] <= (2*DW)'(tree_a) * (2*DW)'(tree_b);
    for (int i = 1; i < PIPE; i++) p_pipe[i] <= p_pipe[i-1];
  end
  assign tree_p = p_pipe[PIPE-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // run one window of n pairs from va/vb; gap idle cycles after each pair,
  // bp cycles of res_ready low in OUT, optional stray start during ISSUE
  task automatic run_window(input int n, input int gap, input int bp, input bit mid_start,
                            output logic [ACC_W-1:0] r, output int l);
    int t0;
    int tries;
    r = '0;
    l = -1;
    res_ready = (bp == 0);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_taps = 5'(n);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b1;
      op_a = va[i];
      op_b = vb[i];
      if (mid_start && i == 1) begin
        start = 1'b1;
        cfg_taps = 5'd1;
      end
      tries = 0;
      @(negedge clk);
      while (!op_ready && tries < 20) begin
        tries++;
        @(negedge clk);
      end
      if (!op_ready) begin
        check("issue_timeout", 32'(op_ready), 32'd1);
        op_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      op_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
    tries = 0;
    @(negedge clk);
    while (!res_valid && tries < 60) begin
      check("drain_op_ready", 32'(op_ready), 32'd0);
      tries++;
      @(negedge clk);
    end
    if (!res_valid) begin
      check("res_timeout", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      return;
    end
    l = cyc - t0;
    r = res_data;
    for (int k = 1; k < bp; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_stable", 32'(res_data), 32'(r));
      check("bp_op_ready", 32'(op_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("res_one_cycle", 32'(res_valid), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
    $display("window n=%0d gap=%0d bp=%0d result=0x%05h latency=%0d", n, gap, bp, r, l);
  endtask

  task automatic bad_start(input logic [4:0] taps);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_taps = taps;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    check("cfg_err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    check("cfg_err_busy2", 32'(busy), 32'd0);
    $display("bad start cfg_taps=%0d checked", taps);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfg_taps = '0;
    op_valid = 1'b1;
    op_a = '0;
    op_b = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_tree_vld", 32'(tree_vld), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    op_valid = 1'b0;

    // sum and latency
    for (int i = 0; i < 9; i++) begin va[i] = 8'(i + 1); vb[i] = 8'sd1; end
    run_window(9, 0, 0, 1'b0, res, lat);
    check("sum45", 32'(res), 32'h0002D);
    check("lat9", 32'(lat), 32'd13);

    // signed extremes
    for (int i = 0; i < 9; i++) begin va[i] = -8'sd128; vb[i] = -8'sd128; end
    run_window(9, 0, 0, 1'b0, res, lat);
    check("ext_pos", 32'(res), 32'h24000);
    for (int i = 0; i < 9; i++) begin va[i] = -8'sd128; vb[i] = 8'sd127; end
    run_window(9, 0, 0, 1'b0, res, lat);
    check("ext_neg", 32'(res), 32'hDC480);

    // input gaps and result backpressure
    for (int i = 0; i < 4; i++) begin va[i] = 8'sd3; vb[i] = -8'sd2; end
    run_window(4, 2, 5, 1'b0, res, lat);
    check("gap_sum", 32'(res), 32'hFFFE8);

    // configuration errors, including the first value above TAPS
    bad_start(5'd0);
    bad_start(5'd17);
    bad_start(5'd10);

    // start while ISSUE must not relatch n or clear acc
    va[0] = 8'sd2; va[1] = 8'sd3; va[2] = 8'sd4;
    vb[0] = 8'sd5; vb[1] = 8'sd5; vb[2] = 8'sd5;
    run_window(3, 0, 0, 1'b1, res, lat);
    check("mid_start_sum", 32'(res), 32'h0002D);

    // reset after 5 of 9 pairs, then a fresh window
    @(posedge clk); #1;
    start = 1'b1;
    cfg_taps = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    op_valid = 1'b1;
    op_a = 8'sd100;
    op_b = 8'sd100;
    repeat (5) @(posedge clk);
    #1;
    op_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    $display("reset applied mid-window");
    va[0] = 8'sd10; va[1] = 8'sd20; vb[0] = 8'sd1; vb[1] = 8'sd1;
    run_window(2, 0, 0, 1'b0, res, lat);
    check("post_rst_sum", 32'(res), 32'h0001E);

    // single tap minimum latency
    va[0] = -8'sd7; vb[0] = 8'sd6;
    run_window(1, 0, 0, 1'b0, res, lat);
    check("single_sum", 32'(res), 32'hFFFD6);
    check("single_lat", 32'(lat), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tap_sequencer.md
Name: mac_tap_sequencer

Overview:
- Sequences one convolution window (up to TAPS operand pairs) through the pipelined signed multiplier / Wallace adder-tree datapath.
- Accepts operand pairs over a valid/ready stream and forwards them to the tree.
- Tracks in-flight products with a valid shift register and accumulates returning products into a signed sum.
- Presents the sum on a valid/ready result port. Sits between the NPU input buffer and the post-processing (bias/activation) stage.

Parameters:
- DW, 8, signed operand width.
- TAPS, 9, maximum taps per window (1..16).
- PIPE, 3, fixed datapath latency in cycles from tree_vld to tree_p.
- ACC_W, 20, accumulator/result width, two's complement.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a window; sampled only in IDLE.
- cfg_taps  in  5  tap count for the window; latched at start.
- cfg_err  out  1  one-cycle pulse: start with cfg_taps==0 or >TAPS.
- busy  out  1  high in any state other than IDLE.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  high only in ISSUE.
- op_a, op_b  in  DW  signed operands.
- tree_vld  out  1  op_valid & op_ready.
- tree_a, tree_b  out  DW  combinational pass-through of op_a/op_b.
- tree_p  in  2*DW  signed product, valid PIPE cycles after tree_vld.
- res_valid  out  1  result valid, high only in OUT.
- res_ready  in  1  result consumer ready.
- res_data  out  ACC_W  accumulated window sum.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state=IDLE, acc=0, issue_cnt=0, ret_cnt=0, vld_sr=0.
  - All outputs 0: busy, op_ready, tree_vld, res_valid, cfg_err; res_data=0.
- Reset asserted mid-window discards in-flight products. No result is ever emitted for that window.
- FSM states: IDLE, ISSUE, DRAIN, OUT.
  - IDLE, start with cfg_taps in 1..TAPS: latch n=cfg_taps, clear acc/issue_cnt/ret_cnt, go to ISSUE.
  - IDLE, start with an invalid cfg_taps: pulse cfg_err, stay in IDLE.
  - ISSUE: op_ready=1. Each handshake increments issue_cnt and shifts a 1 into vld_sr. The handshake with issue_cnt==n-1 goes to DRAIN.
  - DRAIN: op_ready=0. Wait until ret_cnt==n, then go to OUT.
  - OUT: res_valid=1 and res_data=acc, held stable until res_ready. On res_valid&res_ready go to IDLE.
- start outside IDLE is ignored: no error pulse, no effect.
- vld_sr is a PIPE-deep shift register clocked every cycle. It shifts in tree_vld.
- When vld_sr[PIPE-1]=1:
  - acc <= acc + sign_extend(tree_p).
  - ret_cnt increments.
- Returns are accepted in both ISSUE and DRAIN.
- The return that makes ret_cnt==n updates acc and moves DRAIN→OUT on the same edge.
- Minimum latency: start at cycle t0 with one pair per cycle gives res_valid at cycle t0+n+PIPE+1. For n=1, PIPE=3 that is t0+5.
- op_valid gaps stall issue only; the pipeline keeps draining.
- Width: ACC_W=20 cannot overflow for DW=8, TAPS≤16, since |sum| ≤ 16·2^14 = 2^18. For other parameters, acc wraps modulo 2^ACC_W with no saturation.
- res_ready while not in OUT is ignored.

Decomposition:
- Shared package npu_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN/OUT);
  - constants NPU_DW=8, NPU_TAPS=9, NPU_TREE_PIPE=3, NPU_ACC_W=20.
- One sub-module, mac_vld_delay: PIPE-deep valid shift register with synchronous clear. It is reusable for other tree-fed controllers.

Test Plan:
- Sum and latency check:
  - Stimulus: start at cycle 0 with cfg_taps=9, a=1..9, b=1 back-to-back, a model multiplier with PIPE=3, res_ready=1.
  - Response: res_data=45, res_valid at cycle 13 for one cycle, then IDLE.
- Signed extreme:
  - Stimulus: cfg_taps=9, all a=b=-128.
  - Response: res_data=147456 (0x24000).
  - Stimulus: all a=-128, b=127.
  - Response: res_data=-146304 (0xDC480 in 20 bits).
- Input gaps and backpressure:
  - Stimulus: cfg_taps=4, a=3, b=-2, op_valid low for 2 cycles between each pair, res_ready low for 5 cycles in OUT.
  - Response: res_data=-24 (0xFFFE8), stable while res_valid=1, and op_ready=0 throughout DRAIN/OUT.
- Config error and ignored start:
  - Stimulus: start with cfg_taps=0, then start with cfg_taps=17.
  - Response: a cfg_err pulse each time, busy stays 0.
  - Stimulus: start during ISSUE.
  - Response: no effect on n or acc.
- Reset mid-operation:
  - Stimulus: reset for 1 cycle after 5 of 9 pairs issued, then a fresh window with cfg_taps=2, a=10,20, b=1.
  - Response: res_data=30, and no stale product is accumulated.
- Single tap:
  - Stimulus: cfg_taps=1, a=-7, b=6.
  - Response: res_data=-42, res_valid exactly 5 cycles after start.
